// File: rtl/riscv_pkg.sv
// Shared RV32 immediate definitions: format encoding, signed range limits and the
// pipeline beat carried by the instruction packer.
package riscv_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_fmt_t;

   localparam int IMM_IS_MIN = -2048;
   localparam int IMM_IS_MAX = 2047;
   localparam int IMM_B_MIN  = -4096;
   localparam int IMM_B_MAX  = 4094;
   localparam int IMM_J_MIN  = -1048576;
   localparam int IMM_J_MAX  = 1048574;

   typedef struct packed {
      logic [31:0] word;
      logic        err;
   } beat_t;

   function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Handshake bundle between the instruction generator (master) and the packer (slave).
interface instr_packer_if;
   import riscv_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [2:0]  immsrc;
   logic [31:0] imm;
   logic [31:0] base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic        err;
   logic        err_clr;
   logic [15:0] err_count;

   modport master (
      output in_valid, immsrc, imm, base, out_ready, err_clr,
      input  in_ready, out_valid, instr, err, err_count
   );

   modport slave (
      input  in_valid, immsrc, imm, base, out_ready, err_clr,
      output in_ready, out_valid, instr, err, err_count
   );

endinterface

// File: rtl/instr_packer_imm_pack.sv
// Combinational immediate scatter and range check; zero latency, no backpressure.
// Unencodable immediates return the base word untouched with err set.
module imm_pack
   import riscv_pkg::*;
(
   input  logic [2:0]  immsrc,
   input  logic [31:0] imm,
   input  logic [31:0] base,
   output logic [31:0] word,
   output logic        err
);

   logic [31:0] scat;

   always_comb begin
      scat = base;
      err  = 1'b0;
      case (immsrc)
         IMM_I: begin
            scat[31:20] = imm[11:0];
            err         = !in_range(imm, IMM_IS_MIN, IMM_IS_MAX);
         end
         IMM_S: begin
            scat[31:25] = imm[11:5];
            scat[11:7]  = imm[4:0];
            err         = !in_range(imm, IMM_IS_MIN, IMM_IS_MAX);
         end
         IMM_B: begin
            scat[31]    = imm[12];
            scat[30:25] = imm[10:5];
            scat[11:8]  = imm[4:1];
            scat[7]     = imm[11];
            err         = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
         end
         IMM_J: begin
            scat[31]    = imm[20];
            scat[30:21] = imm[10:1];
            scat[20]    = imm[11];
            scat[19:12] = imm[19:12];
            err         = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
         end
         IMM_U: begin
            scat[31:12] = imm[31:12];
            err         = (imm[11:0] != 12'h000);
         end
         default: err = 1'b1;
      endcase
      word = err ? base : scat;
   end

endmodule

// File: rtl/instr_packer.sv
// Immediate encoder: two-stage valid/ready pipe around imm_pack plus a saturating error counter.
// Latency 2 registers; each stage loads when empty or drained, so the pipe holds 2 beats under stall.
module instr_packer
   import riscv_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   instr_packer_if.slave bus
);

   logic [31:0] pk_word;
   logic        pk_err;
   beat_t       pk_dat;
   beat_t       s1_dat;
   beat_t       s2_dat;
   logic        s1_vld;
   logic        s2_vld;
   logic        s1_load;
   logic        s2_load;
   logic [15:0] cnt;

   imm_pack u_pack (
      .immsrc (bus.immsrc),
      .imm    (bus.imm),
      .base   (bus.base),
      .word   (pk_word),
      .err    (pk_err)
   );

   assign pk_dat = '{word: pk_word, err: pk_err};

   // Stage 1 may refill in the same cycle it hands its beat to stage 2.
   assign s2_load      = !s2_vld || bus.out_ready;
   assign s1_load      = !s1_vld || s2_load;
   assign bus.in_ready = s1_load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else if (s1_load) begin
         s1_vld <= bus.in_valid;
         if (bus.in_valid) s1_dat <= pk_dat;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_vld <= 1'b0;
         s2_dat <= '0;
      end else if (s2_load) begin
         s2_vld <= s1_vld;
         if (s1_vld) s2_dat <= s1_dat;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 16'h0000;
      end else if (bus.err_clr) begin
         cnt <= 16'h0000;
      end else if (s2_vld && bus.out_ready && s2_dat.err && (cnt != 16'hFFFF)) begin
         cnt <= cnt + 16'h0001;
      end
   end

   assign bus.out_valid = s2_vld;
   assign bus.instr     = s2_dat.word;
   assign bus.err       = s2_dat.err;
   assign bus.err_count = cnt;

endmodule

// File: tb/tb_instr_packer.sv
// Bench for instr_packer: directed vectors, backpressure, counter, reset and a random
// round-trip scoreboard decoded by a reference immediate extender.
module tb_instr_packer;
   import riscv_pkg::*;

   localparam int NRAND = 10800;

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] v;
      logic [31:0] b;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   instr_packer_if bus();

   instr_packer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Decode-side extender: what a core would recover from the packed word.
   function automatic logic [31:0] ref_ext(input logic [2:0] f, input logic [31:0] i);
      case (f)
         3'd0:    ref_ext = {{20{i[31]}}, i[31:20]};
         3'd1:    ref_ext = {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    ref_ext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    ref_ext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd4:    ref_ext = {i[31:12], 12'h000};
         default: ref_ext = 32'h0;
      endcase
   endfunction

   // Bits of base that are not immediate fields for each format.
   function automatic logic [31:0] keep_mask(input logic [2:0] f);
      case (f)
         3'd0:       keep_mask = 32'h000F_FFFF;
         3'd1, 3'd2: keep_mask = 32'h01FF_F07F;
         3'd3, 3'd4: keep_mask = 32'h0000_0FFF;
         default:    keep_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic legal(input logic [2:0] f, input logic [31:0] v);
      int s;
      s = $signed(v);
      case (f)
         3'd0, 3'd1: legal = (s >= -2048) && (s <= 2047);
         3'd2:       legal = (s >= -4096) && (s <= 4094) && (v[0] == 1'b0);
         3'd3:       legal = (s >= -1048576) && (s <= 1048574) && (v[0] == 1'b0);
         3'd4:       legal = (v[11:0] == 12'h000);
         default:    legal = 1'b0;
      endcase
   endfunction

   task automatic gen_beat(output logic [2:0] f, output logic [31:0] v, output logic [31:0] b);
      f = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) f = 3'($urandom_range(5, 7));
      b = $urandom;
      case (f)
         3'd0, 3'd1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
         3'd2:       v = 32'($urandom_range(0, 4095)) * 32'd2 - 32'd4096;
         3'd3:       v = 32'($urandom_range(0, 1048575)) * 32'd2 - 32'd1048576;
         3'd4:       v = $urandom & 32'hFFFF_F000;
         default:    v = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) v = $urandom;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.err_clr = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks += 4;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
      if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", bus.instr); end
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", bus.err); end
      if (bus.err_count !== 16'h0) begin n_fail++; $display("FAIL rst_err_count got %h want 0", bus.err_count); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
   endtask

   task automatic test_directed();
      logic [2:0]  d_f   [5];
      logic [31:0] d_imm [5];
      logic [31:0] d_base[5];
      logic [31:0] d_exp [5];
      logic        d_err [5];
      logic [15:0] cnt;
      d_f    = '{3'd0, 3'd2, 3'd2, 3'd3, 3'd4};
      d_imm  = '{32'hFFFF_FFFF, 32'd4094, 32'd3, 32'hFFFF_FFFE, 32'h1234_5001};
      d_base = '{32'h0000_0093, 32'h0000_0063, 32'h0000_0063, 32'h0000_00EF, 32'h0000_0037};
      d_exp  = '{32'hFFF0_0093, 32'h7E00_0FE3, 32'h0000_0063, 32'hFFFF_F0EF, 32'h0000_0037};
      d_err  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      cnt = 16'h0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1; bus.immsrc = d_f[k]; bus.imm = d_imm[k]; bus.base = d_base[k];
         bus.out_ready = 1'b1;
         @(negedge clk);
         n_checks++;
         if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got %b want 1", k, bus.in_ready); end
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_latency_early got out_valid %b want 0", k, bus.out_valid); end
         @(negedge clk);
         n_checks += 3;
         if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got out_valid %b want 1", k, bus.out_valid); end
         if (bus.instr !== d_exp[k]) begin n_fail++; $display("FAIL dir%0d_instr got %h want %h", k, bus.instr, d_exp[k]); end
         if (bus.err !== d_err[k]) begin n_fail++; $display("FAIL dir%0d_err got %b want %b", k, bus.err, d_err[k]); end
         if (d_err[k]) cnt = cnt + 16'h1;
         @(negedge clk);
         n_checks += 2;
         if (bus.err_count !== cnt) begin n_fail++; $display("FAIL dir%0d_err_count got %h want %h", k, bus.err_count, cnt); end
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_dup got out_valid %b want 0", k, bus.out_valid); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a_imm [3];
      logic [31:0] a_base[3];
      logic [31:0] hold;
      int idx, acc;
      logic took;
      for (int k = 0; k < 3; k++) begin
         a_imm[k]  = 32'($urandom_range(0, 4095)) - 32'd2048;
         a_base[k] = $urandom;
      end
      idx = 0; acc = 0;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.immsrc = 3'd0; bus.imm = a_imm[0]; bus.base = a_base[0];
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         took = bus.in_valid && bus.in_ready;
         if (took) acc++;
         @(posedge clk); #1;
         if (took) begin
            idx++;
            if (idx < 3) begin bus.imm = a_imm[idx]; bus.base = a_base[idx]; end
            else bus.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_checks += 3;
      if (acc !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", acc); end
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b want 1", bus.out_valid); end
      hold = bus.instr;
      @(negedge clk);
      n_checks++;
      if (bus.instr !== hold) begin n_fail++; $display("FAIL bp_stable got %h want %h", bus.instr, hold); end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks += 3;
         if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rate%0d got out_valid %b want 1", c, bus.out_valid); end
         if (ref_ext(3'd0, bus.instr) !== a_imm[c]) begin n_fail++; $display("FAIL bp_order%0d got imm %h want %h", c, ref_ext(3'd0, bus.instr), a_imm[c]); end
         if ((bus.instr & 32'h000F_FFFF) !== (a_base[c] & 32'h000F_FFFF)) begin n_fail++; $display("FAIL bp_base%0d got %h want base %h", c, bus.instr, a_base[c]); end
         if (c == 0) begin
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_simul got in_ready %b want 1", bus.in_ready); end
         end
         took = bus.in_valid && bus.in_ready;
         if (took) acc++;
         @(posedge clk); #1;
         if (took) bus.in_valid = 1'b0;
      end
      @(negedge clk);
      n_checks += 2;
      if (acc !== 3) begin n_fail++; $display("FAIL bp_total_accepts got %0d want 3", acc); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got out_valid %b want 0", bus.out_valid); end
   endtask

   task automatic test_counter();
      int acc, cyc;
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.immsrc = 3'd7; bus.imm = $urandom; bus.base = $urandom;
      acc = 0; cyc = 0;
      while (acc < 65537 && cyc < 66000) begin
         @(negedge clk);
         cyc++;
         if (bus.in_valid && bus.in_ready) acc++;
         @(posedge clk); #1;
         if (acc == 65537) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_checks += 2;
      if (acc !== 65537) begin n_fail++; $display("FAIL cnt_feed got %0d beats want 65537", acc); end
      if (bus.err_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate got %h want ffff", bus.err_count); end
      @(posedge clk); #1;
      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.err_count !== 16'h0) begin n_fail++; $display("FAIL cnt_clear got %h want 0", bus.err_count); end
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.immsrc = 3'd1; bus.imm = 32'd2048;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.err_count !== 16'h1) begin n_fail++; $display("FAIL cnt_one got %h want 1", bus.err_count); end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.immsrc = 3'd4; bus.imm = 32'h0000_0800;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (bus.out_valid !== 1'b1 && cyc < 10);
      @(posedge clk); #1;
      bus.out_ready = 1'b1; bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (cyc >= 10) begin n_fail++; $display("FAIL cnt_clr_wait got no out_valid within %0d cycles want 1", cyc); end
      if (bus.err_count !== 16'h0) begin n_fail++; $display("FAIL cnt_clr_priority got %h want 0", bus.err_count); end
   endtask

   task automatic test_reset_midflight();
      int cyc, seen;
      logic [31:0] first;
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.immsrc = 3'd5; bus.imm = 32'h0; bus.base = 32'h1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.immsrc = 3'd0; bus.imm = 32'd100; bus.base = 32'h0000_0013;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (bus.in_ready !== 1'b0 && cyc < 10);
      n_checks += 2;
      if (bus.err_count !== 16'h1) begin n_fail++; $display("FAIL mid_precount got %h want 1", bus.err_count); end
      if (cyc >= 10) begin n_fail++; $display("FAIL mid_fill got in_ready %b want 0", bus.in_ready); end
      reset = 1'b1;
      #1;
      n_checks += 4;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
      if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL mid_instr got %h want 0", bus.instr); end
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_err got %b want 0", bus.err); end
      if (bus.err_count !== 16'h0) begin n_fail++; $display("FAIL mid_err_count got %h want 0", bus.err_count); end
      @(posedge clk); #1;
      reset = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_empty got out_valid %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.immsrc = 3'd0; bus.imm = 32'd5; bus.base = 32'h0000_0013;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      seen = 0; first = 32'h0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (seen == 0) first = bus.instr;
            seen++;
         end
      end
      n_checks += 2;
      if (seen !== 1) begin n_fail++; $display("FAIL post_rst_beats got %0d want 1", seen); end
      if (first !== 32'h0050_0013) begin n_fail++; $display("FAIL post_rst_instr got %h want 00500013", first); end
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      logic [2:0]  f;
      logic [31:0] v, b;
      logic took, ok;
      int sent, got, cyc, nerr;
      do_reset();
      sent = 0; got = 0; cyc = 0; nerr = 0;
      gen_beat(f, v, b);
      bus.immsrc = f; bus.imm = v; bus.base = b;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      while (got < NRAND && cyc < 20 * NRAND) begin
         @(negedge clk);
         cyc++;
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rnd_spurious got beat %h want none", bus.instr);
            end else begin
               e = q.pop_front();
               ok = legal(e.f, e.v);
               n_checks++;
               if (bus.err !== !ok) begin n_fail++; $display("FAIL rnd_err fmt %0d imm %h got %b want %b", e.f, e.v, bus.err, !ok); end
               if (ok) begin
                  if (ref_ext(e.f, bus.instr) !== e.v) begin n_fail++; $display("FAIL rnd_roundtrip fmt %0d got %h want %h", e.f, ref_ext(e.f, bus.instr), e.v); end
                  n_checks++;
                  if ((bus.instr & keep_mask(e.f)) !== (e.b & keep_mask(e.f))) begin n_fail++; $display("FAIL rnd_base fmt %0d got %h want base %h", e.f, bus.instr, e.b); end
               end else begin
                  nerr++;
                  if (bus.instr !== e.b) begin n_fail++; $display("FAIL rnd_err_instr got %h want %h", bus.instr, e.b); end
               end
            end
            got++;
         end
         took = bus.in_valid && bus.in_ready;
         if (took) begin
            e.f = bus.immsrc; e.v = bus.imm; e.b = bus.base;
            q.push_back(e);
            sent++;
         end
         @(posedge clk); #1;
         if (took || !bus.in_valid) begin
            if (sent < NRAND && $urandom_range(0, 15) != 0) begin
               gen_beat(f, v, b);
               bus.immsrc = f; bus.imm = v; bus.base = b;
               bus.in_valid = 1'b1;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(0, 15) != 0);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (got !== NRAND) begin n_fail++; $display("FAIL rnd_timeout got %0d beats want %0d", got, NRAND); end
      if (bus.err_count !== 16'(nerr)) begin n_fail++; $display("FAIL rnd_err_count got %h want %h", bus.err_count, 16'(nerr)); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got no end of test want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.err_clr = 1'b0;
      bus.immsrc = 3'd0;
      bus.imm = 32'h0;
      bus.base = 32'h0;
      test_reset();
      test_directed();
      test_backpressure();
      test_counter();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
